// File: rtl/pipe_pkg.sv
// Shared pipeline-control types: hazard FSM state encoding and stage-control bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

  localparam int REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_BR_FLUSH = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERROR    = 2'd3
  } hz_state_e;

  // Per-register controls for one cycle, MSB first as listed.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_write;
    logic mem_wb_flush;
  } hz_ctl_t;

  // Free-running pipeline: every register loads, nothing bubbled.
  localparam hz_ctl_t CTL_RUN    = 7'b1101010;
  // Load-use: hold PC and IF/ID, inject a bubble into ID/EX.
  localparam hz_ctl_t CTL_LU     = 7'b0001110;
  // Taken branch: PC loads target, squash IF/ID and ID/EX.
  localparam hz_ctl_t CTL_BRANCH = 7'b1111110;
  // Extra branch-shadow cycles: only the fetched instruction is squashed.
  localparam hz_ctl_t CTL_BRF    = 7'b1111010;
  // Memory freeze: front stages hold, MEM/WB receives a bubble.
  localparam hz_ctl_t CTL_FREEZE = 7'b0000001;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating 32-bit event counter used for hazard statistics.
// Latency: count visible the cycle after the event.
// Backpressure: none; sticks at all-ones instead of wrapping.
module hazard_perf_cnt (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        inc,
  output logic [31:0] cnt
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // Next count: bump on event unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller (load-use, taken-branch flush, data-memory wait, stall watchdog).
// Latency: controls are a same-cycle decode of registered state and current inputs.
// Backpressure: mem_req && !mem_ready freezes the front of the pipe; HAZARD_PERF_CNT_EN adds perf counters.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW          = REG_AW_DEF,
  parameter int BR_FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_write,
  output logic              id_ex_flush,
  output logic              ex_mem_write,
  output logic              mem_wb_flush,
  output logic              mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       perf_lu_cnt,
  output logic [31:0]       perf_br_cnt,
  output logic [31:0]       perf_mem_cnt
`endif
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  localparam int BCW = $clog2(BR_FLUSH_CYCLES + 1);
  localparam logic [WCW-1:0] WAIT_LIM  = WCW'(MEM_TIMEOUT);
  localparam logic [BCW-1:0] BR_EXTRA  = BCW'(BR_FLUSH_CYCLES - 1);

  hz_state_e      state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [BCW-1:0] br_cnt_q, br_cnt_d;
  logic           timeout_q, timeout_d;

  logic           mem_stall;
  logic           load_use;
  logic           do_run;
  logic [WCW-1:0] wait_inc;
  hz_ctl_t        ctl;

  assign mem_stall = mem_req && !mem_ready;
  assign load_use  = ex_mem_read && (ex_rt != '0) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  // Saturating increment so the wait counter can never wrap back to a small value.
  assign wait_inc  = (wait_cnt_q == '1) ? wait_cnt_q : (wait_cnt_q + WCW'(1));

  // Control decode and next-state logic for the hazard FSM.
  always_comb begin
    ctl        = CTL_RUN;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    br_cnt_d   = br_cnt_q;
    timeout_d  = timeout_q;
    do_run     = 1'b0;

    unique case (state_q)
      ST_ERROR: begin
        ctl = CTL_FREEZE;
      end
      ST_MEM_WAIT: begin
        if (!mem_ready) begin
          ctl        = CTL_FREEZE;
          wait_cnt_d = wait_inc;
          if (wait_inc >= WAIT_LIM) begin
            timeout_d = 1'b1;
            state_d   = ST_ERROR;
          end
        end else begin
          // Access completed: fall through to the normal decode this same cycle.
          do_run = 1'b1;
        end
      end
      default: begin
        do_run = 1'b1;
      end
    endcase

    if (do_run) begin
      state_d    = ST_RUN;
      wait_cnt_d = '0;
      br_cnt_d   = '0;
      if (mem_stall) begin
        // Memory stall outranks everything; any pending branch shadow is dropped.
        ctl        = CTL_FREEZE;
        wait_cnt_d = WCW'(1);
        state_d    = ST_MEM_WAIT;
        if (MEM_TIMEOUT <= 1) begin
          timeout_d = 1'b1;
          state_d   = ST_ERROR;
        end
      end else if (ex_branch_taken) begin
        // A branch also masks a simultaneous load-use: the dependent instruction is squashed.
        ctl = CTL_BRANCH;
        if (BR_FLUSH_CYCLES > 1) begin
          state_d  = ST_BR_FLUSH;
          br_cnt_d = BR_EXTRA;
        end
      end else if (state_q == ST_BR_FLUSH) begin
        ctl = CTL_BRF;
        if (br_cnt_q > BCW'(1)) begin
          state_d  = ST_BR_FLUSH;
          br_cnt_d = br_cnt_q - BCW'(1);
        end
      end else if (load_use) begin
        ctl = CTL_LU;
      end
    end
  end

  // FSM state, wait/flush counters and sticky watchdog flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      br_cnt_q   <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      br_cnt_q   <= br_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Every control is forced low while reset is held, independent of the decode.
  assign pc_write     = reset_n & ctl.pc_write;
  assign if_id_write  = reset_n & ctl.if_id_write;
  assign if_id_flush  = reset_n & ctl.if_id_flush;
  assign id_ex_write  = reset_n & ctl.id_ex_write;
  assign id_ex_flush  = reset_n & ctl.id_ex_flush;
  assign ex_mem_write = reset_n & ctl.ex_mem_write;
  assign mem_wb_flush = reset_n & ctl.mem_wb_flush;
  assign mem_timeout  = reset_n & timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic lu_evt;
  logic br_evt;
  logic mem_evt;

  assign lu_evt  = (ctl == CTL_LU);
  assign br_evt  = (ctl == CTL_BRANCH);
  assign mem_evt = ctl.mem_wb_flush;

  hazard_perf_cnt u_perf_lu (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (lu_evt),
    .cnt     (perf_lu_cnt)
  );

  hazard_perf_cnt u_perf_br (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (br_evt),
    .cnt     (perf_br_cnt)
  );

  hazard_perf_cnt u_perf_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (mem_evt),
    .cnt     (perf_mem_cnt)
  );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: dut_a (3-cycle branch shadow, long watchdog), dut_b (1-cycle shadow, watchdog 4).
// Expected control vectors are queued by the stimulus and checked by a negedge monitor.
// Output vector order: pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_flush, mem_timeout.
module tb_hazard_ctrl;

  localparam logic [7:0] R = 8'h00;  // in reset
  localparam logic [7:0] N = 8'hD4;  // normal run
  localparam logic [7:0] L = 8'h1C;  // load-use stall
  localparam logic [7:0] B = 8'hFC;  // taken branch
  localparam logic [7:0] F = 8'hF4;  // branch shadow
  localparam logic [7:0] Z = 8'h02;  // memory freeze
  localparam logic [7:0] E = 8'h03;  // watchdog error

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, ex_branch_taken, mem_req, mem_ready;

  logic pcw_a, ifw_a, iff_a, iew_a, ief_a, emw_a, mwf_a, mt_a;
  logic pcw_b, ifw_b, iff_b, iew_b, ief_b, emw_b, mwf_b, mt_b;
  logic [7:0] out_a, out_b;
  assign out_a = {pcw_a, ifw_a, iff_a, iew_a, ief_a, emw_a, mwf_a, mt_a};
  assign out_b = {pcw_b, ifw_b, iff_b, iew_b, ief_b, emw_b, mwf_b, mt_b};

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lu_a, br_a, mem_a, lu_b, br_b, mem_b;
`endif

  hazard_ctrl #(.REG_AW(5), .BR_FLUSH_CYCLES(3), .MEM_TIMEOUT(255)) dut_a (
    .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pcw_a), .if_id_write(ifw_a), .if_id_flush(iff_a), .id_ex_write(iew_a),
    .id_ex_flush(ief_a), .ex_mem_write(emw_a), .mem_wb_flush(mwf_a), .mem_timeout(mt_a)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_lu_cnt(lu_a), .perf_br_cnt(br_a), .perf_mem_cnt(mem_a)
`endif
  );

  hazard_ctrl #(.REG_AW(5), .BR_FLUSH_CYCLES(1), .MEM_TIMEOUT(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pcw_b), .if_id_write(ifw_b), .if_id_flush(iff_b), .id_ex_write(iew_b),
    .id_ex_flush(ief_b), .ex_mem_write(emw_b), .mem_wb_flush(mwf_b), .mem_timeout(mt_b)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_lu_cnt(lu_b), .perf_br_cnt(br_b), .perf_mem_cnt(mem_b)
`endif
  );

  typedef struct {
    string      name;
    logic [7:0] ea;
    logic [7:0] eb;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   stim_done = 1'b0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Drive one cycle of inputs just after the edge and queue what both DUTs must show.
  task automatic step(input string nm, input logic rn, input logic [4:0] rs, input logic [4:0] rt,
                      input logic ur, input logic mr, input logic [4:0] ert, input logic br,
                      input logic mq, input logic my, input logic [7:0] ea, input logic [7:0] eb);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n = rn; id_rs = rs; id_rt = rt; id_uses_rt = ur; ex_mem_read = mr;
    ex_rt = ert; ex_branch_taken = br; mem_req = mq; mem_ready = my;
    e.name = nm; e.ea = ea; e.eb = eb;
    q.push_back(e);
  endtask

  task automatic idle(input string nm, input logic [7:0] ea, input logic [7:0] eb);
    step(nm, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ea, eb);
  endtask

  task automatic stall(input string nm, input logic [7:0] ea, input logic [7:0] eb);
    step(nm, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, ea, eb);
  endtask

  task automatic release_mem(input string nm, input logic [7:0] ea, input logic [7:0] eb);
    step(nm, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, ea, eb);
  endtask

  task automatic branch(input string nm, input logic [7:0] ea, input logic [7:0] eb);
    step(nm, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, ea, eb);
  endtask

  // Monitor: whenever an expectation is pending, compare both DUTs mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.name, "_a"}, {24'd0, out_a}, {24'd0, e.ea});
        check({e.name, "_b"}, {24'd0, out_b}, {24'd0, e.eb});
      end
    end
  end

  // Directed stimulus.
  initial begin
    reset_n = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
    ex_rt = '0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    #2 reset_n = 1'b0;

    step("rst", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, R, R);
    idle("idle", N, N);

    // Load-use detection.
    step("lu_rs",        1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, L, L);
    idle("lu_after", N, N);
    step("lu_r0",        1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, N, N);
    step("lu_rt_unused", 1'b1, 5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, N, N);
    step("lu_rt_used",   1'b1, 5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, L, L);
    step("no_load",      1'b1, 5'd8, 5'd0, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, N, N);

    // Branch beats load-use; dut_a keeps flushing IF/ID for two more cycles.
    step("br_lu",        1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, B, B);
    idle("brf1", F, N);
    idle("brf2", F, N);
    idle("brf_done", N, N);

    // New branch inside the shadow reloads the count.
    branch("br2", B, B);
    idle("brf_a", F, N);
    branch("br_reload", B, B);
    idle("brf_r1", F, N);
    idle("brf_r2", F, N);
    idle("brf_r3", N, N);

    // Memory stall inside the shadow discards the remaining flush cycles.
    branch("br3", B, B);
    stall("brf_stall", Z, Z);
    release_mem("stall_rel", N, N);
    idle("post_rel", N, N);

    // Four wait cycles: dut_a releases on cycle 5, dut_b (watchdog 4) trips.
    stall("mw1", Z, Z);
    stall("mw2", Z, Z);
    stall("mw3", Z, Z);
    stall("mw4", Z, Z);
    release_mem("mw_rel", N, E);
    idle("post_to", N, E);

    // Reset in the middle of a freeze clears everything at once.
    stall("frz_a", Z, E);
    step("rst_mid", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, R, R);
    idle("rst_rel", N, N);

    // Fresh run of one load-use, one branch and one 4-cycle memory wait.
    step("p_lu",         1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, L, L);
    idle("p_lu_after", N, N);
    step("p_br_lu",      1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, B, B);
    idle("p_brf1", F, N);
    idle("p_brf2", F, N);
    idle("p_brf_done", N, N);
    stall("p_mw1", Z, Z);
    stall("p_mw2", Z, Z);
    stall("p_mw3", Z, Z);
    stall("p_mw4", Z, Z);
    release_mem("p_mw_rel", N, E);
    idle("p_post", N, E);

    stim_done = 1'b1;
  end

  // Wait (bounded) for the scoreboard to drain, then report.
  initial begin
    int budget;
    budget = 2000;
    while (!(stim_done && q.size() == 0) && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (budget == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
    check("perf_lu_a",  lu_a,  32'd1);
    check("perf_br_a",  br_a,  32'd1);
    check("perf_mem_a", mem_a, 32'd4);
    check("perf_lu_b",  lu_b,  32'd1);
    check("perf_br_b",  br_b,  32'd1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
